// File: rtl/rf_frontend_sequencer_if.sv
// rf_frontend_sequencer_if: serial settings bus write port plus status readback
interface rf_frontend_sequencer_if;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic [31:0] status;
    modport master (output serial_strobe, serial_addr, serial_data, input status);
    modport slave (input serial_strobe, serial_addr, serial_data, output status);
endinterface

// File: rtl/rf_frontend_sequencer.sv
// rf_frontend_sequencer: preset-driven break-before-make RF switch/filter/VCO sequencer
module rf_frontend_sequencer #(
    parameter logic [6:0] BASE_ADDR = 7'd80,
    parameter int NUM_SW    = 4,
    parameter int NUM_FILT  = 2,
    parameter int PRESET_AW = 3,
    parameter int SETTLE_W  = 16,
    parameter int BREAK_CYC = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    rf_frontend_sequencer_if.slave bus,
    input  logic                  step,
    input  logic                  vco_muxout,
    output logic [NUM_SW-1:0]     vsw,
    output logic [NUM_FILT-1:0]   filter_sel,
    output logic                  vco_le,
    output logic                  busy,
    output logic                  settled,
    output logic [PRESET_AW-1:0]  cur_idx
);
    localparam int DEPTH = 2 ** PRESET_AW;
    localparam int BW = $clog2(BREAK_CYC + 1);
    typedef enum logic [2:0] {IDLE, BREAK, MAKE, SETTLE, DONE} state_t;
    state_t st, nxt;
    logic                 sweep_en, lock_check_en, lock_lost, settle_timeout;
    logic [7:0]           sweep_last;
    logic [SETTLE_W-1:0]  settle_cycles, scnt, wcnt;
    logic [BW-1:0]        bcnt;
    logic [1:0]           sync;
    logic                 lock_prev, vco_lock_sync;
    logic                 pend_v, pend_step;
    logic [PRESET_AW-1:0] pend_idx, tgt, last_c, step_idx, use_idx;
    logic [NUM_SW-1:0]    t_sw [DEPTH];
    logic [NUM_FILT-1:0]  t_filt [DEPTH];
    logic                 t_vp [DEPTH];
    logic wr_ctrl, wr_set, wr_pre, wr_app, clr, step_req, new_req, go, use_step;
    logic lock_ok, at_zero, timeout, settle_end, brk_end, ll_set;
    assign wr_ctrl = bus.serial_strobe && bus.serial_addr == BASE_ADDR;
    assign wr_set = bus.serial_strobe && bus.serial_addr == BASE_ADDR + 7'd1;
    assign wr_pre = bus.serial_strobe && bus.serial_addr == BASE_ADDR + 7'd2;
    assign wr_app = bus.serial_strobe && bus.serial_addr == BASE_ADDR + 7'd3;
    assign clr = wr_ctrl && bus.serial_data[2];
    assign vco_lock_sync = sync[1];
    assign step_req = step && sweep_en;
    assign new_req = wr_app || step_req;
    assign go = new_req || pend_v;
    // a fresh request supersedes whatever is parked in the pending slot
    assign use_step = new_req ? !wr_app : pend_step;
    assign use_idx = new_req ? bus.serial_data[PRESET_AW-1:0] : pend_idx;
    assign last_c = int'(sweep_last) > DEPTH - 1 ? PRESET_AW'(DEPTH - 1) : PRESET_AW'(sweep_last);
    assign step_idx = cur_idx >= last_c ? '0 : cur_idx + PRESET_AW'(1);
    assign lock_ok = !lock_check_en || vco_lock_sync;
    assign at_zero = st == SETTLE && scnt == '0;
    assign timeout = at_zero && !lock_ok && wcnt == '1;
    assign settle_end = at_zero && (lock_ok || wcnt == '1);
    assign brk_end = bcnt == BW'(BREAK_CYC - 1);
    assign ll_set = settled && lock_check_en && lock_prev && !vco_lock_sync;
    assign busy = st == BREAK || st == MAKE || st == SETTLE;
    assign bus.status = {lock_lost, settle_timeout, busy, settled, vco_lock_sync, 19'b0, 8'(cur_idx)};
    always_ff @(posedge clock)
        st <= reset ? IDLE : nxt;
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = go ? BREAK : IDLE;
            BREAK:   nxt = brk_end ? MAKE : BREAK;
            MAKE:    nxt = SETTLE;
            SETTLE:  nxt = settle_end ? DONE : SETTLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            lock_prev <= 1'b0;
            sweep_en <= 1'b0;
            lock_check_en <= 1'b0;
            sweep_last <= '0;
            settle_cycles <= SETTLE_W'(1);
            pend_v <= 1'b0;
            pend_step <= 1'b0;
            pend_idx <= '0;
            tgt <= '0;
            bcnt <= '0;
            scnt <= '0;
            wcnt <= '0;
            vsw <= '0;
            filter_sel <= '0;
            vco_le <= 1'b0;
            cur_idx <= '0;
            settled <= 1'b0;
            lock_lost <= 1'b0;
            settle_timeout <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                t_sw[i] <= '0;
                t_filt[i] <= '0;
                t_vp[i] <= 1'b0;
            end
        end else begin
            sync <= {sync[0], vco_muxout};
            lock_prev <= vco_lock_sync;
            if (wr_ctrl) {sweep_last, lock_check_en, sweep_en} <= {bus.serial_data[15:8], bus.serial_data[1:0]};
            if (wr_set) settle_cycles <= bus.serial_data[SETTLE_W-1:0];
            if (wr_pre) begin
                t_sw[bus.serial_data[16 +: PRESET_AW]] <= bus.serial_data[NUM_SW-1:0];
                t_filt[bus.serial_data[16 +: PRESET_AW]] <= bus.serial_data[8 +: NUM_FILT];
                t_vp[bus.serial_data[16 +: PRESET_AW]] <= bus.serial_data[15];
            end
            if (st != IDLE && new_req) {pend_v, pend_step, pend_idx} <= {1'b1, !wr_app, use_idx};
            else if (st == IDLE) pend_v <= 1'b0;
            vco_le <= 1'b0;
            bcnt <= st == BREAK ? bcnt + BW'(1) : '0;
            if (st == IDLE && go) begin
                tgt <= use_step ? step_idx : use_idx;
                vsw <= '0;
                settled <= 1'b0;
            end
            // outputs are latched here, so later table writes cannot disturb them
            if (st == BREAK && brk_end) begin
                vsw <= t_sw[tgt];
                filter_sel <= t_filt[tgt];
                vco_le <= t_vp[tgt];
                cur_idx <= tgt;
            end
            if (st == MAKE) begin
                scnt <= settle_cycles == '0 ? SETTLE_W'(1) : settle_cycles;
                wcnt <= '0;
            end else if (st == SETTLE) begin
                if (scnt != '0) scnt <= scnt - SETTLE_W'(1);
                else if (wcnt != '1) wcnt <= wcnt + SETTLE_W'(1);
            end
            if (settle_end) settled <= 1'b1;
            settle_timeout <= timeout || (!clr && settle_timeout);
            lock_lost <= ll_set || (!clr && lock_lost);
        end
    end
endmodule
